// File: rtl/div_despachador_if.sv
// -----------------------------------------------------------------------------
// div_despachador_if
//   Operand and result handshakes of the division dispatcher.
//   Producer side : in_valid / in_ready / in_num / in_den
//   Consumer side : out_valid / out_ready / out_coc / out_res / out_err
//   master : the environment (drives operands, accepts results)
//   slave  : the dispatcher (accepts operands, offers results)
// -----------------------------------------------------------------------------
interface div_despachador_if #(
    parameter int tamanyo = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [tamanyo-1:0] in_num;
    logic [tamanyo-1:0] in_den;
    logic               out_valid;
    logic               out_ready;
    logic [tamanyo-1:0] out_coc;
    logic [tamanyo-1:0] out_res;
    logic [1:0]         out_err;

    modport master (
        output in_valid, in_num, in_den, out_ready,
        input  in_ready, out_valid, out_coc, out_res, out_err
    );

    modport slave (
        input  in_valid, in_num, in_den, out_ready,
        output in_ready, out_valid, out_coc, out_res, out_err
    );
endinterface

// File: rtl/div_despachador.sv
// -----------------------------------------------------------------------------
// div_despachador
//   Upstream sequencer for a multi-cycle signed divider. Operand pairs are
//   queued in a small FIFO, one division at a time is launched with a single
//   Start pulse, and the quotient/remainder is returned on a valid/ready port.
//   A zero divisor is answered locally (err[0]); a divider that never reports
//   Done is abandoned after TIMEOUT cycles (err[1]).
// Ports
//   CLK, RSTa        clock (rising edge), asynchronous active-low reset
//   bus              operand/result handshakes (div_despachador_if.slave)
//   div_start        one-cycle Start pulse to the divider
//   div_num/div_den  operands to the divider, held after the pulse
//   div_done         one-cycle Done from the divider
//   div_coc/div_res  divider quotient/remainder, valid with div_done
//   busy             work queued or in progress
//   n_pend           FIFO occupancy
// -----------------------------------------------------------------------------
module div_despachador #(
    parameter int tamanyo = 32,
    parameter int PROF    = 4,
    parameter int TIMEOUT = 80
) (
    input  logic                    CLK,
    input  logic                    RSTa,
    div_despachador_if.slave        bus,
    output logic                    div_start,
    output logic [tamanyo-1:0]      div_num,
    output logic [tamanyo-1:0]      div_den,
    input  logic                    div_done,
    input  logic [tamanyo-1:0]      div_coc,
    input  logic [tamanyo-1:0]      div_res,
    output logic                    busy,
    output logic [$clog2(PROF):0]   n_pend
);

    localparam int PW = $clog2(PROF);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LANZA   = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    // FIFO storage and bookkeeping
    logic [tamanyo-1:0] mem_num_r [PROF];
    logic [tamanyo-1:0] mem_den_r [PROF];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_next_s;
    logic               push_s;
    logic               pop_s;
    logic [tamanyo-1:0] head_num_s;
    logic [tamanyo-1:0] head_den_s;

    // Sequencer state and registered outputs
    estado_t            estado_r;
    estado_t            estado_s;
    logic [TW-1:0]      wd_r;
    logic [TW-1:0]      wd_s;
    logic [tamanyo-1:0] out_coc_r;
    logic [tamanyo-1:0] out_coc_s;
    logic [tamanyo-1:0] out_res_r;
    logic [tamanyo-1:0] out_res_s;
    logic [1:0]         out_err_r;
    logic [1:0]         out_err_s;
    logic [tamanyo-1:0] div_num_r;
    logic [tamanyo-1:0] div_num_s;
    logic [tamanyo-1:0] div_den_r;
    logic [tamanyo-1:0] div_den_s;
    logic               out_valid_r;
    logic               div_start_r;
    logic               in_ready_r;
    logic               busy_r;

    // in_ready_r is the registered "not full" flag, so a full FIFO never
    // accepts a push even when the sequencer pops in the same cycle.
    assign push_s     = bus.in_valid && in_ready_r;
    assign pop_s      = (estado_r == IDLE) && (cnt_r != {CW{1'b0}});
    assign head_num_s = mem_num_r[rd_ptr_r];
    assign head_den_s = mem_den_r[rd_ptr_r];

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        cnt_next_s = cnt_r;
        if (push_s && !pop_s) begin
            cnt_next_s = cnt_r + CW'(1'b1);
        end else if (pop_s && !push_s) begin
            cnt_next_s = cnt_r - CW'(1'b1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // FIFO storage, pointers (wrap naturally, PROF is a power of 2) and count
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            for (int i = 0; i < PROF; i++) begin
                mem_num_r[i] <= {tamanyo{1'b0}};
                mem_den_r[i] <= {tamanyo{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_num_r[wr_ptr_r] <= bus.in_num;
                mem_den_r[wr_ptr_r] <= bus.in_den;
                wr_ptr_r            <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            cnt_r <= cnt_next_s;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        estado_s  = estado_r;
        wd_s      = wd_r;
        out_coc_s = out_coc_r;
        out_res_s = out_res_r;
        out_err_s = out_err_r;
        div_num_s = div_num_r;
        div_den_s = div_den_r;
        case (estado_r)
            IDLE: begin
                if (pop_s) begin
                    if (head_den_s == {tamanyo{1'b0}}) begin
                        // Zero divisor is answered here; the divider never sees it.
                        out_coc_s = {tamanyo{1'b0}};
                        out_res_s = head_num_s;
                        out_err_s = 2'b01;
                        estado_s  = ENTREGA;
                    end else begin
                        div_num_s = head_num_s;
                        div_den_s = head_den_s;
                        estado_s  = LANZA;
                    end
                end else begin
                    estado_s = IDLE;
                end
            end
            LANZA: begin
                wd_s     = {TW{1'b0}};
                estado_s = ESPERA;
            end
            ESPERA: begin
                // Done is checked first so it wins over a coinciding timeout.
                if (div_done) begin
                    out_coc_s = div_coc;
                    out_res_s = div_res;
                    out_err_s = 2'b00;
                    estado_s  = ENTREGA;
                end else if (wd_r == TW'(TIMEOUT - 1)) begin
                    out_coc_s = {tamanyo{1'b0}};
                    out_res_s = {tamanyo{1'b0}};
                    out_err_s = 2'b10;
                    estado_s  = ENTREGA;
                end else begin
                    wd_s = wd_r + TW'(1'b1);
                end
            end
            ENTREGA: begin
                if (bus.out_ready) begin
                    estado_s = IDLE;
                end else begin
                    estado_s = ENTREGA;
                end
            end
            default: begin
                estado_s = IDLE;
            end
        endcase
    end

    // State register and registered outputs; strobes decode the next state
    // so they are aligned with the state they belong to.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            estado_r    <= IDLE;
            wd_r        <= {TW{1'b0}};
            out_coc_r   <= {tamanyo{1'b0}};
            out_res_r   <= {tamanyo{1'b0}};
            out_err_r   <= 2'b00;
            div_num_r   <= {tamanyo{1'b0}};
            div_den_r   <= {tamanyo{1'b0}};
            out_valid_r <= 1'b0;
            div_start_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            estado_r    <= estado_s;
            wd_r        <= wd_s;
            out_coc_r   <= out_coc_s;
            out_res_r   <= out_res_s;
            out_err_r   <= out_err_s;
            div_num_r   <= div_num_s;
            div_den_r   <= div_den_s;
            out_valid_r <= (estado_s == ENTREGA);
            div_start_r <= (estado_s == LANZA);
            in_ready_r  <= (cnt_next_s != CW'(PROF));
            busy_r      <= (estado_s != IDLE) || (cnt_next_s != {CW{1'b0}});
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_coc   = out_coc_r;
    assign bus.out_res   = out_res_r;
    assign bus.out_err   = out_err_r;
    assign div_start     = div_start_r;
    assign div_num       = div_num_r;
    assign div_den       = div_den_r;
    assign busy          = busy_r;
    assign n_pend        = cnt_r;

endmodule

// File: tb/tb_div_despachador.sv
// -----------------------------------------------------------------------------
// tb_div_despachador
//   Directed bench for div_despachador with a behavioural divider stub
//   (Done 65 cycles after the edge that samples Start). Expected results are
//   queued when operands are driven and popped when the dispatcher delivers.
// -----------------------------------------------------------------------------
module tb_div_despachador;

    localparam int W = 32;

    typedef struct {
        logic [31:0] coc;
        logic [31:0] res;
        logic [1:0]  err;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RSTa;
    logic           div_start;
    logic           div_done;
    logic           stub_done;
    logic           late_done;
    logic           stub_on;
    logic [W-1:0]   div_num;
    logic [W-1:0]   div_den;
    logic [W-1:0]   div_coc;
    logic [W-1:0]   div_res;
    logic           busy;
    logic [2:0]     n_pend;
    int             stub_cnt;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             n_start = 0;
    int             t_start = 0;
    int             t_done = 0;
    int             t_valid = 0;
    int             s0;
    int             t0;
    logic           prev_valid = 1'b0;
    logic           held = 1'b0;
    logic [31:0]    held_coc;
    logic [31:0]    held_res;
    logic [1:0]     held_err;
    exp_t           sb_q[$];

    always #5 CLK = ~CLK;

    div_despachador_if #(.tamanyo(W)) ifc ();

    div_despachador #(.tamanyo(W), .PROF(4), .TIMEOUT(80)) dut (
        .CLK       (CLK),
        .RSTa      (RSTa),
        .bus       (ifc.slave),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_done  (div_done),
        .div_coc   (div_coc),
        .div_res   (div_res),
        .busy      (busy),
        .n_pend    (n_pend)
    );

    // Divider stub: Done and result 65 cycles after the edge sampling Start
    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
            div_coc   <= '0;
            div_res   <= '0;
        end else begin
            stub_done <= 1'b0;
            if (div_start) begin
                stub_cnt <= 65;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && stub_on) begin
                    stub_done <= 1'b1;
                    div_coc   <= $signed(div_num) / $signed(div_den);
                    div_res   <= $signed(div_num) % $signed(div_den);
                end
            end
        end
    end

    assign div_done = stub_done | late_done;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: scoreboard compare on handshake, stability while stalled
    always @(negedge CLK) begin
        exp_t e;
        if (!RSTa) begin
            held       = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (div_start) begin
                n_start++;
                t_start = cyc;
            end
            if (div_done) t_done = cyc;
            if (ifc.out_valid && !prev_valid) t_valid = cyc;
            if (ifc.out_valid) begin
                if (held) begin
                    check("hold_coc", ifc.out_coc, held_coc);
                    check("hold_res", ifc.out_res, held_res);
                    check("hold_err", {30'd0, ifc.out_err}, {30'd0, held_err});
                end
                if (ifc.out_ready) begin
                    check("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("out_coc", ifc.out_coc, e.coc);
                        check("out_res", ifc.out_res, e.res);
                        check("out_err", {30'd0, ifc.out_err}, {30'd0, e.err});
                    end
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_coc = ifc.out_coc;
                    held_res = ifc.out_res;
                    held_err = ifc.out_err;
                end
            end else begin
                held = 1'b0;
            end
            prev_valid = ifc.out_valid;
        end
    end

    task automatic push(input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] ec, input logic [31:0] er, input logic [1:0] ee);
        int w;
        exp_t e;
        w = 0;
        e.coc = ec;
        e.res = er;
        e.err = ee;
        sb_q.push_back(e);
        ifc.in_num   = n;
        ifc.in_den   = d;
        ifc.in_valid = 1'b1;
        @(negedge CLK);
        while (!ifc.in_ready && w < 2000) begin
            @(negedge CLK);
            w++;
        end
        check("push_accepted", {31'd0, (w < 2000)}, 32'd1);
        @(posedge CLK);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        @(negedge CLK);
        while ((busy || ifc.out_valid || sb_q.size() != 0) && w < 3000) begin
            @(negedge CLK);
            w++;
        end
        check(tag, {31'd0, (w < 3000)}, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTa          = 1'b0;
        stub_on       = 1'b1;
        late_done     = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_num    = '0;
        ifc.in_den    = '0;
        ifc.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_n_pend", {29'd0, n_pend}, 32'd0);
        check("rst_div_start", {31'd0, div_start}, 32'd0);
        RSTa = 1'b1;
        @(negedge CLK);
        check("in_ready_after_release", {31'd0, ifc.in_ready}, 32'd1);
        @(posedge CLK);
        #1;

        // 1) 100/7
        s0 = n_start;
        push(32'd100, 32'd7, 32'd14, 32'd2, 2'b00);
        wait_idle("idle_t1");
        check("t1_starts", n_start - s0, 32'd1);
        check("t1_done_to_valid", t_valid - t_done, 32'd1);
        check("t1_num_held", div_num, 32'd100);
        check("t1_den_held", div_den, 32'd7);

        // 2) signed operands, order preserved
        s0 = n_start;
        push(-32'sd100, 32'd7, -32'sd14, -32'sd2, 2'b00);
        push(32'd100, -32'sd7, -32'sd14, 32'd2, 2'b00);
        wait_idle("idle_t2");
        check("t2_starts", n_start - s0, 32'd2);

        // 3) zero divisor in the middle
        s0 = n_start;
        push(32'd9, 32'd2, 32'd4, 32'd1, 2'b00);
        push(32'd5, 32'd0, 32'd0, 32'd5, 2'b01);
        push(32'd8, 32'd3, 32'd2, 32'd2, 2'b00);
        wait_idle("idle_t3");
        check("t3_starts", n_start - s0, 32'd2);

        // 3b) zero divisor alone: driven after edge t, out_valid after edge t+2
        s0 = n_start;
        t0 = cyc;
        push(-32'sd5, 32'd0, 32'd0, -32'sd5, 2'b01);
        wait_idle("idle_t3b");
        check("t3b_latency", t_valid - t0, 32'd2);
        check("t3b_starts", n_start - s0, 32'd0);

        // 4) back-pressure: FIFO fills, outputs hold, then drain in order
        ifc.out_ready = 1'b0;
        push(32'd20, 32'd3, 32'd6, 32'd2, 2'b00);
        push(-32'sd20, 32'd3, -32'sd6, -32'sd2, 2'b00);
        push(32'd20, -32'sd3, -32'sd6, 32'd2, 2'b00);
        push(-32'sd20, -32'sd3, 32'd6, -32'sd2, 2'b00);
        push(32'd7, 32'd7, 32'd1, 32'd0, 2'b00);
        @(negedge CLK);
        check("t4_full_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        check("t4_n_pend", {29'd0, n_pend}, 32'd4);
        repeat (150) @(negedge CLK);
        check("t4_stalled_valid", {31'd0, ifc.out_valid}, 32'd1);
        check("t4_still_full", {31'd0, ifc.in_ready}, 32'd0);
        @(posedge CLK);
        #1;
        ifc.out_ready = 1'b1;
        push(32'd0, 32'd5, 32'd0, 32'd0, 2'b00);
        wait_idle("idle_t4");

        // 5) divider never answers: timeout, then a late Done is ignored
        stub_on = 1'b0;
        push(32'd11, 32'd4, 32'd0, 32'd0, 2'b10);
        wait_idle("idle_t5");
        check("t5_timeout_latency", t_valid - t_start - 1, 32'd80);
        late_done = 1'b1;
        @(posedge CLK);
        #1;
        late_done = 1'b0;
        repeat (5) @(negedge CLK);
        check("t5_late_valid", {31'd0, ifc.out_valid}, 32'd0);
        check("t5_late_busy", {31'd0, busy}, 32'd0);
        stub_on = 1'b1;
        @(posedge CLK);
        #1;

        // 6) reset while waiting with 3 queued pairs
        push(32'd50, 32'd5, 32'd10, 32'd0, 2'b00);
        push(32'd51, 32'd5, 32'd10, 32'd1, 2'b00);
        push(32'd52, 32'd5, 32'd10, 32'd2, 2'b00);
        push(32'd53, 32'd5, 32'd10, 32'd3, 2'b00);
        repeat (6) @(posedge CLK);
        #1;
        check("t6_n_pend_before", {29'd0, n_pend}, 32'd3);
        RSTa = 1'b0;
        #1;
        check("t6_n_pend", {29'd0, n_pend}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        check("t6_div_num", div_num, 32'd0);
        check("t6_out_coc", ifc.out_coc, 32'd0);
        sb_q.delete();
        @(negedge CLK);
        RSTa = 1'b1;
        @(posedge CLK);
        #1;
        push(32'd10, 32'd3, 32'd3, 32'd1, 2'b00);
        wait_idle("idle_t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
